sent_rx_crc_sched: RTL and testbench

Sequential CRC check scheduler for the SENT receiver. It buffers completed fast-channel frames and serial-channel messages (short or enhanced) from the frame decoders. It arbitrates them onto one shared bit-serial CRC remainder engine and reports a one-cycle valid or error pulse per checked item. It sits between the nibble decoder / serial message assembler and the receive output registers.

---
 rtl/sent_rx_pkg.sv | 25 ++
 rtl/sent_rx_crc_lfsr.sv | 35 +++
 rtl/sent_rx_crc_sched.sv | 203 ++++++++++++++++++++
 tb/tb_sent_rx_crc_sched.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sent_rx_pkg.sv
// Shared definitions for the SENT receiver CRC scheduler: CRC seeds, reduced
// polynomials, payload lengths, item kinds and engine states.
package sent_rx_pkg;

    typedef enum logic [1:0] {FAST, SHORT, ENH} kind_e;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam logic [5:0] SEED_W4 = 6'b000101;
    localparam logic [5:0] POLY_W4 = 6'b001101;
    localparam logic [5:0] SEED_W6 = 6'b010101;
    localparam logic [5:0] POLY_W6 = 6'b011001;

    localparam logic [4:0] LEN_FAST  = 5'd28;
    localparam logic [4:0] LEN_SHORT = 5'd16;
    localparam logic [4:0] LEN_ENH   = 5'd30;

    function automatic logic [4:0] kind_last_idx(input kind_e k);
        case (k)
            FAST:    return LEN_FAST - 5'd1;
            SHORT:   return LEN_SHORT - 5'd1;
            default: return LEN_ENH - 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/sent_rx_crc_lfsr.sv
// Bit-serial CRC remainder register (4- or 6-bit). The zero flag reports the
// remainder as it will be after this cycle's load/shift.
module sent_rx_crc_lfsr
    import sent_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic shift,
    input  logic wide,
    input  logic bit_in,
    output logic zero
);

    logic [5:0] r_q, r_d;

    always_comb begin
        r_d = r_q;
        if (load) begin
            r_d = wide ? SEED_W6 : SEED_W4;
        end else if (shift) begin
            // 4-bit mode keeps r[5:4] at zero.
            if (wide) r_d = {r_q[4:0], bit_in} ^ (r_q[5] ? POLY_W6 : 6'd0);
            else      r_d = {2'b00, r_q[2:0], bit_in} ^ (r_q[3] ? POLY_W4 : 6'd0);
        end
    end

    assign zero = (r_d == 6'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= 6'd0;
        else     r_q <= r_d;
    end

endmodule

// File: rtl/sent_rx_crc_sched.sv
// SENT receive CRC scheduler: one holding slot per requester, round-robin onto a
// shared bit-serial CRC engine. Optional error counters: SENT_RX_CRC_ERRCNT_EN.
module sent_rx_crc_sched
    import sent_rx_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic        clk_rx,
    input  logic        reset_rx,
    input  logic        fast_req,
    input  logic [27:0] fast_data,
    input  logic        serial_req,
    input  logic        serial_enh,
    input  logic [29:0] serial_data,
    output logic        busy,
    output logic        valid_data_fast,
    output logic        valid_data_serial,
    output logic        valid_data_enhanced,
    output logic        crc_err_fast,
    output logic        crc_err_serial,
    output logic        overrun_fast,
    output logic        overrun_serial
`ifdef SENT_RX_CRC_ERRCNT_EN
    ,
    input  logic             err_cnt_clr,
    output logic [CNT_W-1:0] err_cnt_fast,
    output logic [CNT_W-1:0] err_cnt_serial
`endif
);

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic        last_ser_q, last_ser_d;
    logic        fhold_v_q, fhold_v_d, shold_v_q, shold_v_d;
    logic [27:0] fhold_q, fhold_d;
    logic [29:0] shold_q, shold_d;
    logic        shold_enh_q, shold_enh_d;
    logic [29:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        vld_fast_q, vld_fast_d, vld_ser_q, vld_ser_d, vld_enh_q, vld_enh_d;
    logic        err_fast_q, err_fast_d, err_ser_q, err_ser_d;
    logic        ovr_fast_q, ovr_fast_d, ovr_ser_q, ovr_ser_d;
    logic        grant_f, grant_s, lfsr_load, lfsr_shift, lfsr_wide, lfsr_zero;

    sent_rx_crc_lfsr u_lfsr (
        .clk    (clk_rx),
        .rst    (reset_rx),
        .load   (lfsr_load),
        .shift  (lfsr_shift),
        .wide   (lfsr_wide),
        .bit_in (shreg_q[29]),
        .zero   (lfsr_zero)
    );

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        last_ser_d = last_ser_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        vld_fast_d = 1'b0;
        vld_ser_d  = 1'b0;
        vld_enh_d  = 1'b0;
        err_fast_d = 1'b0;
        err_ser_d  = 1'b0;
        grant_f    = 1'b0;
        grant_s    = 1'b0;
        lfsr_load  = 1'b0;
        lfsr_shift = 1'b0;
        lfsr_wide  = (kind_q == ENH);
        case (state_q)
            IDLE: begin
                // On a tie the requester not served last wins.
                grant_f = fhold_v_q && (!shold_v_q || last_ser_q);
                grant_s = shold_v_q && !grant_f;
                if (grant_f || grant_s) begin
                    state_d    = SHIFT;
                    lfsr_load  = 1'b1;
                    last_ser_d = grant_s;
                    if (grant_f) begin
                        kind_d    = FAST;
                        shreg_d   = {fhold_q, 2'b00};
                        lfsr_wide = 1'b0;
                    end else if (shold_enh_q) begin
                        kind_d    = ENH;
                        shreg_d   = shold_q;
                        lfsr_wide = 1'b1;
                    end else begin
                        kind_d    = SHORT;
                        shreg_d   = {shold_q[15:0], 14'd0};
                        lfsr_wide = 1'b0;
                    end
                    cnt_d = kind_last_idx(kind_d);
                end
            end
            SHIFT: begin
                lfsr_shift = 1'b1;
                shreg_d    = {shreg_q[28:0], 1'b0};
                if (cnt_q == 5'd0) begin
                    state_d = DONE;
                    case (kind_q)
                        FAST:    begin vld_fast_d = lfsr_zero; err_fast_d = !lfsr_zero; end
                        SHORT:   begin vld_ser_d  = lfsr_zero; err_ser_d  = !lfsr_zero; end
                        default: begin vld_enh_d  = lfsr_zero; err_ser_d  = !lfsr_zero; end
                    endcase
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A slot being granted this cycle counts as empty, so it refills.
        ovr_fast_d  = fast_req && fhold_v_q && !grant_f;
        fhold_v_d   = (fhold_v_q && !grant_f) || fast_req;
        fhold_d     = (fast_req && !ovr_fast_d) ? fast_data : fhold_q;
        ovr_ser_d   = serial_req && shold_v_q && !grant_s;
        shold_v_d   = (shold_v_q && !grant_s) || serial_req;
        shold_d     = (serial_req && !ovr_ser_d) ? serial_data : shold_q;
        shold_enh_d = (serial_req && !ovr_ser_d) ? serial_enh : shold_enh_q;
    end

    always_ff @(posedge clk_rx or posedge reset_rx) begin
        if (reset_rx) begin
            state_q    <= IDLE;
            kind_q     <= FAST;
            last_ser_q <= 1'b1;
            fhold_v_q  <= 1'b0;
            shold_v_q  <= 1'b0;
            cnt_q      <= 5'd0;
            vld_fast_q <= 1'b0;
            vld_ser_q  <= 1'b0;
            vld_enh_q  <= 1'b0;
            err_fast_q <= 1'b0;
            err_ser_q  <= 1'b0;
            ovr_fast_q <= 1'b0;
            ovr_ser_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            last_ser_q <= last_ser_d;
            fhold_v_q  <= fhold_v_d;
            shold_v_q  <= shold_v_d;
            cnt_q      <= cnt_d;
            vld_fast_q <= vld_fast_d;
            vld_ser_q  <= vld_ser_d;
            vld_enh_q  <= vld_enh_d;
            err_fast_q <= err_fast_d;
            err_ser_q  <= err_ser_d;
            ovr_fast_q <= ovr_fast_d;
            ovr_ser_q  <= ovr_ser_d;
        end
    end

    always_ff @(posedge clk_rx) begin
        fhold_q     <= fhold_d;
        shold_q     <= shold_d;
        shold_enh_q <= shold_enh_d;
        shreg_q     <= shreg_d;
    end

    assign busy                = (state_q != IDLE);
    assign valid_data_fast     = vld_fast_q;
    assign valid_data_serial   = vld_ser_q;
    assign valid_data_enhanced = vld_enh_q;
    assign crc_err_fast        = err_fast_q;
    assign crc_err_serial      = err_ser_q;
    assign overrun_fast        = ovr_fast_q;
    assign overrun_serial      = ovr_ser_q;

`ifdef SENT_RX_CRC_ERRCNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] ecnt_f_q, ecnt_f_d, ecnt_s_q, ecnt_s_d;

    // Saturating counters; clear has priority over a same-cycle increment.
    always_comb begin
        ecnt_f_d = ecnt_f_q;
        ecnt_s_d = ecnt_s_q;
        if (err_cnt_clr) begin
            ecnt_f_d = '0;
            ecnt_s_d = '0;
        end else begin
            if (err_fast_q && (ecnt_f_q != '1)) ecnt_f_d = ecnt_f_q + CNT_ONE;
            if (err_ser_q && (ecnt_s_q != '1))  ecnt_s_d = ecnt_s_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_rx or posedge reset_rx) begin
        if (reset_rx) begin
            ecnt_f_q <= '0;
            ecnt_s_q <= '0;
        end else begin
            ecnt_f_q <= ecnt_f_d;
            ecnt_s_q <= ecnt_s_d;
        end
    end

    assign err_cnt_fast   = ecnt_f_q;
    assign err_cnt_serial = ecnt_s_q;
`endif

endmodule

// File: tb/tb_sent_rx_crc_sched.sv
// Randomized and directed bench for sent_rx_crc_sched against a transaction-level
// model (slots, round-robin, fixed check latency, polynomial-division CRC).
module tb_sent_rx_crc_sched;

    localparam int CNT_W = 8;

    logic        clk_rx = 1'b0;
    logic        reset_rx = 1'b1;
    logic        fast_req = 1'b0;
    logic [27:0] fast_data = '0;
    logic        serial_req = 1'b0;
    logic        serial_enh = 1'b0;
    logic [29:0] serial_data = '0;
    logic        busy, valid_data_fast, valid_data_serial, valid_data_enhanced;
    logic        crc_err_fast, crc_err_serial, overrun_fast, overrun_serial;
`ifdef SENT_RX_CRC_ERRCNT_EN
    logic             err_cnt_clr = 1'b0;
    logic [CNT_W-1:0] err_cnt_fast, err_cnt_serial;
`endif

    sent_rx_crc_sched #(.CNT_W(CNT_W)) dut (
        .clk_rx              (clk_rx),
        .reset_rx            (reset_rx),
        .fast_req            (fast_req),
        .fast_data           (fast_data),
        .serial_req          (serial_req),
        .serial_enh          (serial_enh),
        .serial_data         (serial_data),
        .busy                (busy),
        .valid_data_fast     (valid_data_fast),
        .valid_data_serial   (valid_data_serial),
        .valid_data_enhanced (valid_data_enhanced),
        .crc_err_fast        (crc_err_fast),
        .crc_err_serial      (crc_err_serial),
        .overrun_fast        (overrun_fast),
        .overrun_serial      (overrun_serial)
`ifdef SENT_RX_CRC_ERRCNT_EN
        ,
        .err_cnt_clr         (err_cnt_clr),
        .err_cnt_fast        (err_cnt_fast),
        .err_cnt_serial      (err_cnt_serial)
`endif
    );

    always #5 clk_rx = ~clk_rx;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk_rx);
        cyc++;
    end

    // Pulse vector: [0] vld fast [1] vld short [2] vld enh [3] err fast [4] err serial [5] ovr fast [6] ovr serial
    function automatic logic [6:0] dut_pul();
        return {overrun_serial, overrun_fast, crc_err_serial, crc_err_fast,
                valid_data_enhanced, valid_data_serial, valid_data_fast};
    endfunction

    // CRC by polynomial division with the full generator (kind 0 fast, 1 short, 2 enhanced).
    function automatic bit crc_ok(input int kind, input logic [29:0] d);
        int n, w, poly, r;
        if (kind == 0)      begin n = 28; w = 4; poly = 'h1D; r = 'h05; end
        else if (kind == 1) begin n = 16; w = 4; poly = 'h1D; r = 'h05; end
        else                begin n = 30; w = 6; poly = 'h59; r = 'h15; end
        for (int i = n - 1; i >= 0; i--) begin
            r = (r << 1) | (d[i] ? 1 : 0);
            if (((r >> w) & 1) == 1) r = r ^ poly;
        end
        return r == 0;
    endfunction

    function automatic logic [29:0] make_valid(input int kind, input logic [29:0] payload);
        int n, w;
        logic [29:0] d, mask;
        n = (kind == 0) ? 28 : (kind == 1) ? 16 : 30;
        w = (kind == 2) ? 6 : 4;
        mask = (30'd1 << n) - 30'd1;
        for (int c = 0; c < (1 << w); c++) begin
            d = ((payload << w) | 30'(c)) & mask;
            if (crc_ok(kind, d)) return d;
        end
        return '0;
    endfunction

    // Transaction-level model, advanced on every clock edge.
    logic        m_fv, m_sv, m_senh, m_last_ser, m_pass;
    logic [27:0] m_fd;
    logic [29:0] m_sd;
    int          m_left, m_kind;
    logic [6:0]  e_pul = '0;
    logic        e_busy = 1'b0;
    int          m_cf, m_cs;

    initial begin
        int g;
        m_fv = 0; m_sv = 0; m_senh = 0; m_last_ser = 1; m_pass = 0;
        m_fd = '0; m_sd = '0; m_left = 0; m_kind = 0; m_cf = 0; m_cs = 0;
        forever begin
            @(posedge clk_rx);
            if (reset_rx) begin
                m_fv = 0; m_sv = 0; m_last_ser = 1; m_left = 0;
                e_pul = '0; e_busy = 0; m_cf = 0; m_cs = 0;
            end else begin
`ifdef SENT_RX_CRC_ERRCNT_EN
                if (err_cnt_clr) begin
                    m_cf = 0; m_cs = 0;
                end else begin
                    if (e_pul[3] && m_cf != (1 << CNT_W) - 1) m_cf++;
                    if (e_pul[4] && m_cs != (1 << CNT_W) - 1) m_cs++;
                end
`endif
                g = 0;
                if (m_left == 0) begin
                    if (m_fv && (!m_sv || m_last_ser)) g = 1;
                    else if (m_sv) g = 2;
                end
                e_pul = '0;
                if (m_left > 0) m_left--;
                if (g == 1) begin
                    m_kind = 0; m_pass = crc_ok(0, {2'b00, m_fd});
                    m_fv = 0; m_last_ser = 0; m_left = 29;
                end else if (g == 2) begin
                    m_kind = m_senh ? 2 : 1; m_pass = crc_ok(m_kind, m_sd);
                    m_sv = 0; m_last_ser = 1; m_left = (m_senh ? 30 : 16) + 1;
                end
                if (fast_req) begin
                    if (m_fv) e_pul[5] = 1'b1;
                    else begin m_fv = 1; m_fd = fast_data; end
                end
                if (serial_req) begin
                    if (m_sv) e_pul[6] = 1'b1;
                    else begin m_sv = 1; m_sd = serial_data; m_senh = serial_enh; end
                end
                e_busy = (m_left > 0);
                if (m_left == 1) begin
                    if (m_kind == 0)      e_pul[m_pass ? 0 : 3] = 1'b1;
                    else if (m_kind == 1) e_pul[m_pass ? 1 : 4] = 1'b1;
                    else                  e_pul[m_pass ? 2 : 4] = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        logic [7:0] act, expv;
        @(negedge clk_rx);
        if (!reset_rx) begin
            act  = {busy, dut_pul()};
            expv = {e_busy, e_pul};
            n_cmp++;
            if (act !== expv) begin
                n_err++;
                $display("FAIL outputs cyc %0d: {busy,pulses} got %b want %b", cyc, act, expv);
            end
`ifdef SENT_RX_CRC_ERRCNT_EN
            n_cmp++;
            if (err_cnt_fast !== CNT_W'(m_cf) || err_cnt_serial !== CNT_W'(m_cs)) begin
                n_err++;
                $display("FAIL err_cnt cyc %0d: got %0d/%0d want %0d/%0d",
                         cyc, err_cnt_fast, err_cnt_serial, m_cf, m_cs);
            end
`endif
        end
    end

    task automatic check_val(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_rx); #1; end
    endtask

    task automatic send_fast(input logic [27:0] d, output int t);
        fast_req = 1; fast_data = d; t = cyc;
        @(posedge clk_rx); #1;
        fast_req = 0;
    endtask

    task automatic send_serial(input logic enh, input logic [29:0] d, output int t);
        serial_req = 1; serial_enh = enh; serial_data = d; t = cyc;
        @(posedge clk_rx); #1;
        serial_req = 0;
    endtask

    task automatic send_both(input logic [27:0] fd, input logic enh, input logic [29:0] sd, output int t);
        fast_req = 1; fast_data = fd;
        serial_req = 1; serial_enh = enh; serial_data = sd; t = cyc;
        @(posedge clk_rx); #1;
        fast_req = 0; serial_req = 0;
    endtask

    // Waits for pulse bit idx and checks its cycle relative to request cycle t0.
    task automatic wait_pulse(input int t0, input int exp_rel, input int idx, input string nm);
        logic [6:0] p;
        int rel;
        bit hit;
        hit = 0; rel = -1;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk_rx);
            p = dut_pul();
            if (p[idx]) begin hit = 1; rel = cyc - t0; end
        end
        check_val(nm, rel, exp_rel);
        @(posedge clk_rx); #1;
    endtask

    initial begin
        int t0, t1, t2, seen;
        logic [29:0] tmp;

        check_val("model crc fast 0x5", int'(crc_ok(0, 30'h5)), 1);
        check_val("model crc fast 0x0", int'(crc_ok(0, 30'h0)), 0);
        check_val("model crc short 0x9", int'(crc_ok(1, 30'h9)), 1);
        check_val("model crc short 0x0", int'(crc_ok(1, 30'h0)), 0);
        check_val("model crc enh 0x26", int'(crc_ok(2, 30'h26)), 1);
        check_val("model crc enh 0x27", int'(crc_ok(2, 30'h27)), 0);

        idle(3);
        @(negedge clk_rx);
        check_val("reset busy+pulses", int'({busy, dut_pul()}), 0);
`ifdef SENT_RX_CRC_ERRCNT_EN
        check_val("reset err_cnt", int'(err_cnt_fast) + int'(err_cnt_serial), 0);
`endif
        @(posedge clk_rx); #1;
        reset_rx = 0;
        idle(2);

        send_fast(28'h0000005, t0);    wait_pulse(t0, 30, 0, "fast pass latency");
        send_fast(28'h0000000, t0);    wait_pulse(t0, 30, 3, "fast fail latency");
        send_serial(0, 30'h0009, t0);  wait_pulse(t0, 18, 1, "short pass latency");
        send_serial(0, 30'h0000, t0);  wait_pulse(t0, 18, 4, "short fail latency");
        send_serial(1, 30'h26, t0);    wait_pulse(t0, 32, 2, "enh pass latency");
        send_serial(1, 30'h27, t0);    wait_pulse(t0, 32, 4, "enh fail latency");

        send_both(28'h5, 0, 30'h9, t0);
        wait_pulse(t0, 30, 0, "tie1 fast first");
        wait_pulse(t0, 48, 1, "tie1 serial second");
        send_fast(28'h0, t0);          wait_pulse(t0, 30, 3, "fast between ties");
        send_both(28'h5, 0, 30'h9, t0);
        wait_pulse(t0, 18, 1, "tie2 serial first");
        wait_pulse(t0, 48, 0, "tie2 fast second");

        send_serial(1, 30'h26, t0);
        idle(2);
        send_fast(28'h5, t1);
        idle(2);
        send_fast(28'h0, t2);
        wait_pulse(t2, 1, 5, "overrun_fast");
        wait_pulse(t0, 32, 2, "enh during overrun");
        wait_pulse(t1, 62 - (t1 - t0), 0, "held fast after overrun");

        send_fast(28'h5, t0);
        idle(8);
        reset_rx = 1;
        @(negedge clk_rx);
        check_val("mid-check reset outputs", int'({busy, dut_pul()}), 0);
        @(posedge clk_rx); #1;
        idle(1);
        reset_rx = 0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_rx);
            if (dut_pul() != 7'd0 || busy) seen++;
        end
        check_val("no activity after abort", seen, 0);
        @(posedge clk_rx); #1;
        send_fast(28'h5, t0);          wait_pulse(t0, 30, 0, "fast after reset");

        for (int i = 0; i < 3000; i++) begin
            fast_req = ($urandom_range(0, 24) == 0);
            tmp = $urandom_range(0, 1) ? make_valid(0, 30'($urandom)) : 30'($urandom);
            fast_data = tmp[27:0];
            serial_req = ($urandom_range(0, 24) == 0);
            serial_enh = $urandom_range(0, 1) == 1;
            serial_data = $urandom_range(0, 1) ? make_valid(serial_enh ? 2 : 1, 30'($urandom))
                                               : 30'($urandom);
`ifdef SENT_RX_CRC_ERRCNT_EN
            err_cnt_clr = ($urandom_range(0, 199) == 0);
`endif
            @(posedge clk_rx); #1;
        end
        fast_req = 0; serial_req = 0;
`ifdef SENT_RX_CRC_ERRCNT_EN
        err_cnt_clr = 0;
`endif
        idle(80);

`ifdef SENT_RX_CRC_ERRCNT_EN
        err_cnt_clr = 1; idle(1); err_cnt_clr = 0;
        for (int i = 0; i < 300; i++) begin
            send_fast(28'h0, t0);
            wait_pulse(t0, 30, 3, "saturation run fail");
        end
        check_val("err_cnt_fast saturated", int'(err_cnt_fast), 255);
        err_cnt_clr = 1; idle(1); err_cnt_clr = 0;
        check_val("err_cnt_fast cleared", int'(err_cnt_fast), 0);
`endif

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
